// File: rtl/aes_dom_byte_io.sv
// Byte-serial adapter between 128-bit plaintext/key registers and a byte-serial AES DOM core.
// Feeds plaintext/key bytes, collects ciphertext bytes, drives the scope trigger and a watchdog.
module aes_dom_byte_io #(
   parameter int unsigned NBYTES  = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   ptxt,
   input  logic [8*NBYTES-1:0]   key,
   input  logic [7:0]            trg_delay,
   output logic                  core_start,
   output logic [7:0]            pin,
   output logic [7:0]            kin,
   input  logic                  core_done,
   input  logic [7:0]            cout,
   output logic [8*NBYTES-1:0]   ctxt,
   output logic                  busy,
   output logic                  valid,
   output logic                  err,
   output logic                  trg
);

   localparam int unsigned W       = 8 * NBYTES;
   localparam int unsigned CNT_W   = $clog2(NBYTES + 1);
   localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_COLLECT
   } state_t;

   state_t             state, state_nxt;
   logic [W-1:0]       p_sr, p_sr_nxt;
   logic [W-1:0]       k_sr, k_sr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WD_W-1:0]    wd, wd_nxt;
   logic [7:0]         tcnt, tcnt_nxt;
   logic               core_start_nxt;
   logic [7:0]         pin_nxt, kin_nxt;
   logic [W-1:0]       ctxt_nxt;
   logic               busy_nxt, valid_nxt, err_nxt, trg_nxt;

   // State and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         p_sr       <= '0;
         k_sr       <= '0;
         cnt        <= '0;
         wd         <= '0;
         tcnt       <= '0;
         core_start <= 1'b0;
         pin        <= '0;
         kin        <= '0;
         ctxt       <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         err        <= 1'b0;
         trg        <= 1'b0;
      end else begin
         state      <= state_nxt;
         p_sr       <= p_sr_nxt;
         k_sr       <= k_sr_nxt;
         cnt        <= cnt_nxt;
         wd         <= wd_nxt;
         tcnt       <= tcnt_nxt;
         core_start <= core_start_nxt;
         pin        <= pin_nxt;
         kin        <= kin_nxt;
         ctxt       <= ctxt_nxt;
         busy       <= busy_nxt;
         valid      <= valid_nxt;
         err        <= err_nxt;
         trg        <= trg_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt      = state;
      p_sr_nxt       = p_sr;
      k_sr_nxt       = k_sr;
      cnt_nxt        = cnt;
      wd_nxt         = wd;
      ctxt_nxt       = ctxt;
      busy_nxt       = busy;
      err_nxt        = err;
      core_start_nxt = 1'b0;
      valid_nxt      = 1'b0;
      pin_nxt        = 8'h00;
      kin_nxt        = 8'h00;
      // Trigger counter runs regardless of FSM state; trg fires the cycle after it reads 1
      trg_nxt        = (tcnt == 8'd1);
      tcnt_nxt       = (tcnt != 8'd0) ? tcnt - 8'd1 : tcnt;

      case (state)
         S_IDLE: begin
            if (start) begin
               p_sr_nxt       = ptxt;
               k_sr_nxt       = key;
               cnt_nxt        = '0;
               err_nxt        = 1'b0;
               core_start_nxt = 1'b1;
               busy_nxt       = 1'b1;
               tcnt_nxt       = trg_delay;
               state_nxt      = S_LOAD;
            end
         end

         S_LOAD: begin
            if (cnt == CNT_W'(NBYTES)) begin
               wd_nxt    = '0;
               state_nxt = S_WAIT;
            end else begin
               pin_nxt  = p_sr[W-1 -: 8];
               kin_nxt  = k_sr[W-1 -: 8];
               p_sr_nxt = {p_sr[W-9:0], 8'h00};
               k_sr_nxt = {k_sr[W-9:0], 8'h00};
               cnt_nxt  = cnt + CNT_W'(1);
            end
         end

         S_WAIT: begin
            if (core_done) begin
               ctxt_nxt  = {ctxt[W-9:0], cout};
               cnt_nxt   = CNT_W'(1);
               state_nxt = S_COLLECT;
            end else if (TIMEOUT != 0) begin
               // Counter stops at TIMEOUT; reaching it aborts without touching ctxt
               wd_nxt = wd + WD_W'(1);
               if (wd == WD_W'(WD_LAST)) begin
                  err_nxt   = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = S_IDLE;
               end
            end
         end

         S_COLLECT: begin
            ctxt_nxt = {ctxt[W-9:0], cout};
            cnt_nxt  = cnt + CNT_W'(1);
            if (cnt == CNT_W'(NBYTES - 1)) begin
               valid_nxt = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_dom_byte_io.sv
// Directed self-checking bench for aes_dom_byte_io (TIMEOUT=32).
module tb_aes_dom_byte_io;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] ptxt, key;
   logic [7:0]   trg_delay;
   logic         core_start;
   logic [7:0]   pin, kin;
   logic         core_done;
   logic [7:0]   cout;
   logic [127:0] ctxt;
   logic         busy, valid, err, trg;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P2 = 128'hfedcba98765432100123456789abcdef;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_dom_byte_io #(.NBYTES(16), .TIMEOUT(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ptxt       (ptxt),
      .key        (key),
      .trg_delay  (trg_delay),
      .core_start (core_start),
      .pin        (pin),
      .kin        (kin),
      .core_done  (core_done),
      .cout       (cout),
      .ctxt       (ctxt),
      .busy       (busy),
      .valid      (valid),
      .err        (err),
      .trg        (trg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk_b({tag, "_core_start"}, core_start, 1'b0);
      chk_8({tag, "_pin"}, pin, 8'h00);
      chk_8({tag, "_kin"}, kin, 8'h00);
      chk_w({tag, "_ctxt"}, ctxt, 128'h0);
      chk_b({tag, "_busy"}, busy, 1'b0);
      chk_b({tag, "_valid"}, valid, 1'b0);
      chk_b({tag, "_err"}, err, 1'b0);
      chk_b({tag, "_trg"}, trg, 1'b0);
   endtask

   // Called in c0; steps to c0+16 checking feed bytes and trigger; optional glitch of start/core_done
   task automatic load_check(input logic [127:0] p, input logic [127:0] k, input int dly,
                             input int glitch_at);
      for (int c = 1; c <= 16; c++) begin
         if (c == glitch_at) begin
            start = 1'b1; core_done = 1'b1; cout = 8'ha5;
         end else if (c == glitch_at + 1) begin
            start = 1'b0; core_done = 1'b0; cout = 8'h00;
         end
         tick();
         chk_8("feed_pin", pin, p[127-8*(c-1) -: 8]);
         chk_8("feed_kin", kin, k[127-8*(c-1) -: 8]);
         chk_b("feed_trg", trg, (c == dly));
         chk_b("feed_no_core_start", core_start, 1'b0);
      end
      start = 1'b0; core_done = 1'b0; cout = 8'h00;
   endtask

   // Called in cycle d; drives 16 ciphertext bytes and returns in cycle d+16
   task automatic feed_core(input logic [127:0] ct, input int start_at, input logic hold);
      for (int i = 0; i < 16; i++) begin
         core_done = (i == 0);
         cout      = ct[127-8*i -: 8];
         start     = hold | (i == start_at);
         tick();
         chk_b("collect_no_core_start", core_start, 1'b0);
         if (i < 15) chk_b("collect_busy", busy, 1'b1);
      end
      core_done = 1'b0;
      cout      = 8'h00;
      start     = hold;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ptxt = '0; key = '0; trg_delay = 8'd0;
      core_done = 1'b0; cout = 8'h00;
      tick();
      tick();
      chk_zero_outputs("reset");
      rst = 1'b0;
      tick();
      chk_b("idle_busy", busy, 1'b0);

      // Basic encryption, trigger delay 5
      ptxt = P1; key = K1; trg_delay = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      chk_b("c0_core_start", core_start, 1'b1);
      chk_b("c0_busy", busy, 1'b1);
      chk_b("c0_trg", trg, 1'b0);
      chk_8("c0_pin", pin, 8'h00);
      load_check(P1, K1, 5, -5);
      tick();
      chk_8("wait_pin", pin, 8'h00);
      chk_8("wait_kin", kin, 8'h00);
      chk_b("wait_busy", busy, 1'b1);
      repeat (23) tick();
      feed_core(C1, -1, 1'b0);
      chk_b("basic_valid", valid, 1'b1);
      chk_w("basic_ctxt", ctxt, C1);
      chk_b("basic_busy_low", busy, 1'b0);
      tick();
      chk_b("basic_valid_pulse", valid, 1'b0);
      chk_w("basic_ctxt_hold", ctxt, C1);

      // Ignored start/core_done, trigger delay 1
      ptxt = P2; key = K2; trg_delay = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk_b("ign_core_start", core_start, 1'b1);
      chk_b("ign_c0_trg", trg, 1'b0);
      load_check(P2, K2, 1, 4);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_b("ign_wait_core_start", core_start, 1'b0);
      chk_b("ign_wait_busy", busy, 1'b1);
      repeat (2) tick();
      feed_core(C2, 5, 1'b0);
      chk_b("ign_valid", valid, 1'b1);
      chk_w("ign_ctxt", ctxt, C2);
      tick();
      chk_b("ign_no_restart", core_start, 1'b0);
      chk_b("ign_idle", busy, 1'b0);

      // Watchdog, no trigger
      ptxt = P3; key = K3; trg_delay = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk_b("wd_core_start", core_start, 1'b1);
      chk_b("wd_c0_trg", trg, 1'b0);
      load_check(P3, K3, 0, -5);
      repeat (32) tick();
      chk_b("wd_pre_err", err, 1'b0);
      chk_b("wd_pre_busy", busy, 1'b1);
      chk_b("wd_trg", trg, 1'b0);
      tick();
      chk_b("wd_err", err, 1'b1);
      chk_b("wd_busy", busy, 1'b0);
      chk_b("wd_valid", valid, 1'b0);
      chk_w("wd_ctxt", ctxt, C2);
      tick();
      chk_b("wd_err_sticky", err, 1'b1);
      chk_b("wd_no_valid", valid, 1'b0);

      // Next start clears err; reset lands during COLLECT at byte 7
      ptxt = P1; key = K1; start = 1'b1;
      tick();
      start = 1'b0;
      chk_b("err_cleared", err, 1'b0);
      chk_b("rst_txn_core_start", core_start, 1'b1);
      load_check(P1, K1, 0, -5);
      repeat (4) tick();
      for (int i = 0; i < 8; i++) begin
         core_done = (i == 0);
         cout      = C1[127-8*i -: 8];
         if (i < 7) tick();
      end
      chk_b("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk_zero_outputs("midrst");
      core_done = 1'b0; cout = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk_b("post_rst_valid", valid, 1'b0);
      chk_b("post_rst_busy", busy, 1'b0);
      ptxt = P2; key = K2; trg_delay = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      chk_b("post_rst_core_start", core_start, 1'b1);
      load_check(P2, K2, 3, -5);
      repeat (4) tick();
      feed_core(C3, -1, 1'b0);
      chk_b("post_rst_txn_valid", valid, 1'b1);
      chk_w("post_rst_txn_ctxt", ctxt, C3);
      tick();

      // Back-to-back with start held high
      ptxt = P1; key = K1; trg_delay = 8'd2; start = 1'b1;
      tick();
      chk_b("b2b_core_start1", core_start, 1'b1);
      load_check(P1, K1, 2, -5);
      start = 1'b1;
      ptxt = P3; key = K3;
      repeat (4) tick();
      feed_core(C2, -1, 1'b1);
      chk_b("b2b_valid1", valid, 1'b1);
      chk_w("b2b_ctxt1", ctxt, C2);
      chk_b("b2b_busy_gap", busy, 1'b0);
      tick();
      start = 1'b0;
      chk_b("b2b_core_start2", core_start, 1'b1);
      chk_b("b2b_busy2", busy, 1'b1);
      chk_b("b2b_valid_drop", valid, 1'b0);
      load_check(P3, K3, 2, -5);
      repeat (4) tick();
      feed_core(C1, -1, 1'b0);
      chk_b("b2b_valid2", valid, 1'b1);
      chk_w("b2b_ctxt2", ctxt, C1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
